// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute bus, aligns/extends load data,
// drives writeback and the decode bypass, and holds SRAM read data across stalls.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 76,
    parameter int MS_TO_WS_BUS_WD = 70,
    parameter int MS_TO_DS_BUS_WD = 38
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

    typedef struct packed {
        logic [4:0]  ld_inst;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_bus_t;

    logic                       ms_valid_q, ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
    logic                       entry_q, entry_d;
    logic                       rdata_buf_vld_q, rdata_buf_vld_d;
    logic [31:0]                rdata_buf_q, rdata_buf_d;

    es_bus_t     ms_bus;
    logic        ms_ready_go;
    logic        load_en;
    logic        leave;
    logic [31:0] rdata;
    logic [1:0]  off;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;
    logic [31:0] final_result;

    assign ms_bus      = bus_q;
    assign ms_ready_go = 1'b1;

    always_comb begin
        ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid_q && ms_ready_go;
        load_en        = es_to_ms_valid && ms_allowin;
        leave          = ms_to_ws_valid && ws_allowin;

        ms_valid_d = ms_allowin ? es_to_ms_valid : ms_valid_q;
        bus_d      = load_en ? es_to_ms_bus : bus_q;
        // Read data is only live in the cycle right after acceptance.
        entry_d    = load_en;

        rdata_buf_vld_d = rdata_buf_vld_q;
        rdata_buf_d     = rdata_buf_q;
        if (leave) begin
            rdata_buf_vld_d = 1'b0;
        end else if (entry_q && ms_valid_q && ms_bus.res_from_mem && !ws_allowin) begin
            rdata_buf_vld_d = 1'b1;
            rdata_buf_d     = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q      <= 1'b0;
            bus_q           <= '0;
            entry_q         <= 1'b0;
            rdata_buf_vld_q <= 1'b0;
            rdata_buf_q     <= '0;
        end else begin
            ms_valid_q      <= ms_valid_d;
            bus_q           <= bus_d;
            entry_q         <= entry_d;
            rdata_buf_vld_q <= rdata_buf_vld_d;
            rdata_buf_q     <= rdata_buf_d;
        end
    end

    always_comb begin
        rdata    = rdata_buf_vld_q ? rdata_buf_q : data_sram_rdata;
        off      = ms_bus.result[1:0];
        sel_half = off[1] ? rdata[31:16] : rdata[15:0];
        case (off)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        // Unencoded loads (ld_inst == 0) fall through to a full word.
        if (ms_bus.ld_inst[0])      load_val = {{24{sel_byte[7]}}, sel_byte};
        else if (ms_bus.ld_inst[1]) load_val = {24'd0, sel_byte};
        else if (ms_bus.ld_inst[2]) load_val = {{16{sel_half[15]}}, sel_half};
        else if (ms_bus.ld_inst[3]) load_val = {16'd0, sel_half};
        else                        load_val = rdata;
        final_result = ms_bus.res_from_mem ? load_val : ms_bus.result;
    end

    assign ms_to_ws_bus = {ms_bus.gr_we, ms_bus.dest, final_result, ms_bus.pc};
    assign ms_to_ds_bus = {ms_valid_q && ms_bus.gr_we, ms_bus.dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writeback beats,
// a negedge monitor pops and compares each accepted beat.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [37:0] ms_to_ds_bus;

    int tests = 0;
    int fails = 0;
    logic [69:0] exp_q[$];

    mem_stage dut (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .data_sram_rdata(data_sram_rdata), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_to_ws_bus(ms_to_ws_bus), .ms_to_ds_bus(ms_to_ds_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [75:0] mk(input logic [4:0] ld, input logic rfm, input logic we,
                                        input logic [4:0] dest, input logic [31:0] res,
                                        input logic [31:0] pc);
        return {ld, rfm, we, dest, res, pc};
    endfunction

    // Present one instruction and push its expected writeback beat.
    task automatic issue(input logic [75:0] b, input logic [31:0] fin, input bit push);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        if (push) exp_q.push_back({b[69], b[68:64], fin, b[31:0]});
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
    endtask

    task automatic idle();
        es_to_ms_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got %h expected none", ms_to_ws_bus);
            end else begin
                check("ws_beat", ms_to_ws_bus, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] ld_exp [8];
        logic [4:0]  ld_sel [8];
        logic [1:0]  ld_off [8];
        int wait_cnt;
        ld_sel = '{5'h01, 5'h02, 5'h01, 5'h01, 5'h04, 5'h08, 5'h04, 5'h10};
        ld_off = '{2'd3,  2'd3,  2'd1,  2'd2,  2'd2,  2'd2,  2'd0,  2'd0};
        ld_exp = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'hFFFFFFFF,
                   32'hFFFF80FF, 32'h000080FF, 32'h00007F01, 32'h80FF7F01};

        reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0; data_sram_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_allowin", 70'(ms_allowin), 70'(1));
        check("rst_ws_valid", 70'(ms_to_ws_valid), 70'(0));
        check("rst_ds_we", 70'(ms_to_ds_bus[37]), 70'(0));

        // ALU op: result passes through unchanged.
        issue(mk(5'h0, 1'b0, 1'b1, 5'd5, 32'h12345678, 32'h1C000000), 32'h12345678, 1);
        check("alu_ds_bus", 70'(ms_to_ds_bus), 70'({1'b1, 5'd5, 32'h12345678}));
        idle();

        // Byte / half / word loads, back to back with constant read data.
        data_sram_rdata = 32'h80FF7F01;
        for (int i = 0; i < 8; i++) begin
            issue(mk(ld_sel[i], 1'b1, 1'b1, 5'(i + 1), {30'h04000000, ld_off[i]},
                     32'h1C000100 + 32'(i * 4)), ld_exp[i], 1);
            check("ld_back2back_valid", 70'(ms_to_ws_valid), 70'(1));
        end
        idle();

        // Four consecutive ALU ops: no bubbles, buffer never used.
        for (int i = 0; i < 4; i++) begin
            issue(mk(5'h0, 1'b0, 1'b1, 5'd10, 32'hA0 + 32'(i), 32'h1C000200 + 32'(i * 4)),
                  32'hA0 + 32'(i), 1);
            check("tput_valid", 70'(ms_to_ws_valid), 70'(1));
            check("tput_allowin", 70'(ms_allowin), 70'(1));
            check("tput_buf_vld", 70'(dut.rdata_buf_vld_q), 70'(0));
        end
        idle();

        // Stall: load enters, writeback blocked for three cycles, SRAM data goes away.
        ws_allowin = 1'b0;
        issue(mk(5'h10, 1'b1, 1'b1, 5'd7, 32'h00001000, 32'h1C000300), 32'hDEADBEEF, 1);
        data_sram_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        data_sram_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            check("stall_allowin", 70'(ms_allowin), 70'(0));
            check("stall_ds_result", 70'(ms_to_ds_bus[31:0]), 70'(32'hDEADBEEF));
            @(posedge clk); #1;
        end
        check("stall_hold_valid", 70'(ms_to_ws_valid), 70'(1));
        ws_allowin = 1'b1;
        @(posedge clk); #1;
        check("stall_release_empty", 70'(ms_to_ws_valid), 70'(0));
        idle();

        // Reset while a buffered load is held.
        ws_allowin = 1'b0;
        issue(mk(5'h10, 1'b1, 1'b1, 5'd9, 32'h00002000, 32'h1C000400), 32'h0, 0);
        data_sram_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        data_sram_rdata = 32'h0;
        check("midrst_buf_set", 70'(dut.rdata_buf_vld_q), 70'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_ws_valid", 70'(ms_to_ws_valid), 70'(0));
        check("midrst_ds_we", 70'(ms_to_ds_bus[37]), 70'(0));
        check("midrst_allowin", 70'(ms_allowin), 70'(1));
        ws_allowin = 1'b1;
        issue(mk(5'h10, 1'b1, 1'b1, 5'd11, 32'h00003000, 32'h1C000500), 32'h0BADF00D, 1);
        data_sram_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        data_sram_rdata = 32'h0;

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        check("scoreboard_drained", 70'(exp_q.size()), 70'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, sitting between the execute stage and the writeback stage.
- Latches the execute-stage bus and takes the synchronous data-SRAM read data, one cycle after the request is issued upstream.
- Aligns and extends load data, then produces the final writeback result.
- Provides a forwarding/bypass bus back to decode.
- Buffers SRAM read data so that writeback back-pressure cannot corrupt it.

Parameters:
- ES_TO_MS_BUS_WD, 76, width of the incoming execute-to-memory bus.
- MS_TO_WS_BUS_WD, 70, width of the outgoing memory-to-writeback bus.
- MS_TO_DS_BUS_WD, 38, width of the forwarding bus to decode.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ws_allowin  input  1  writeback stage can accept an instruction this cycle.
- ms_allowin  output  1  this stage can accept an instruction this cycle.
- es_to_ms_valid  input  1  execute stage presents a valid instruction.
- es_to_ms_bus  input  76  {ld_inst[4:0] 75:71, res_from_mem 70, gr_we 69, dest[4:0] 68:64, result[31:0] 63:32, pc[31:0] 31:0}.
- data_sram_rdata  input  32  read data for the request issued in the previous cycle.
- ms_to_ws_valid  output  1  valid instruction is forwarded to writeback.
- ms_to_ws_bus  output  70  {gr_we 69, dest 68:64, final_result 63:32, pc 31:0}.
- ms_to_ds_bus  output  38  {we 37, dest 36:32, final_result 31:0}.

Behaviour:
- Clocking and reset:
  - Reset is synchronous on clk, active-high.
  - ms_valid=0, rdata_buf_vld=0, bus register cleared to 0.
  - Outputs after reset: ms_allowin=1, ms_to_ws_valid=0, ms_to_ds_bus we=0.
- Handshake:
  - ms_ready_go=1 (fixed).
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - When ms_allowin=1: ms_valid <= es_to_ms_valid.
  - Bus register is loaded only when es_to_ms_valid && ms_allowin; otherwise it holds.
  - Entry and exit in the same cycle are allowed (full throughput, one instruction per cycle).
- Load-data capture:
  - data_sram_rdata is valid only in the first cycle an instruction occupies this stage (the "entry cycle").
  - rdata_buf_vld is set in that entry cycle if ms_valid && res_from_mem && !ws_allowin; rdata_buf captures data_sram_rdata at the same time.
  - rdata_buf_vld clears when the instruction leaves (ms_to_ws_valid && ws_allowin), and on reset.
  - Effective read data = rdata_buf_vld ? rdata_buf : data_sram_rdata.
  - If an instruction is accepted in the same cycle the buffered one leaves, the buffer is cleared and the new instruction starts with rdata_buf_vld=0.
- Load alignment:
  - Byte offset off = result[1:0].
  - Selected byte = rdata[8*off+7 : 8*off].
  - Selected half = off[1] ? rdata[31:16] : rdata[15:0].
  - ld_inst one-hot encoding:
    - bit0 ld.b: sign-extend byte.
    - bit1 ld.bu: zero-extend byte.
    - bit2 ld.h: sign-extend half.
    - bit3 ld.hu: zero-extend half.
    - bit4 ld.w: full word.
  - res_from_mem=1 with ld_inst=0 is treated as ld.w.
  - Misaligned half/word accesses are not checked; off[0] is ignored for halfwords and off is ignored for words.
- final_result = res_from_mem ? load value : result.
- Forwarding (ms_to_ds_bus):
  - we = ms_valid && gr_we.
  - dest and final_result are taken from the current register contents.
  - While a stall holds an instruction, its fields and final_result stay stable.
- Output when empty:
  - ms_to_ws_bus is don't-care when ms_to_ws_valid=0.
  - The bench checks ms_to_ws_bus only when ms_to_ws_valid=1.
- Reset mid-operation:
  - Any held instruction and buffered data are discarded.
  - The next cycle shows ms_valid=0.

Test Plan:
- Reset, then one ALU op: es bus gr_we=1, dest=5, result=0x1234_5678, pc=0x1C00_0000 → next cycle ms_to_ws_valid=1, final_result=0x12345678; ms_to_ds_bus = {1, 5, 0x12345678}.
- Byte loads with rdata=0x80FF_7F01 and ws_allowin=1:
  - ld.b off=3 → 0xFFFFFF80.
  - ld.bu off=3 → 0x00000080.
  - ld.b off=1 → 0x0000007F.
  - ld.b off=2 → 0xFFFFFFFF.
- Half-word loads with rdata=0x80FF_7F01:
  - ld.h off=2 → 0xFFFF80FF.
  - ld.hu off=2 → 0x000080FF.
  - ld.h off=0 → 0x00007F01.
  - ld.w → 0x80FF7F01.
- Stall buffering: ld.w enters with rdata=0xDEADBEEF and ws_allowin=0 for 3 cycles, while rdata changes to 0x0 the cycle after entry → ms_allowin=0 throughout the stall; final_result stays 0xDEADBEEF; on release the bus delivers 0xDEADBEEF exactly once.
- Back-to-back throughput: 4 consecutive valid instructions with ws_allowin=1 → 4 consecutive ms_to_ws_valid pulses with matching pcs in order; no bubbles; rdata_buf_vld never set.
- Reset mid-stall: a load is held with rdata_buf_vld=1 and reset is asserted → next cycle ms_to_ws_valid=0, forwarding we=0, ms_allowin=1; the next load after reset uses the live data_sram_rdata.
